spi_byte_queue: RTL and testbench

Host-side buffering stage directly upstream of SPI_cont.
- TX path: queues bytes from the host and feeds them to SPI_cont over the W_STB/W_DATA/W_ACK handshake.
- RX path: collects received bytes from SPI_cont over R_STB/R_DATA/R_ACK into a second FIFO for the host to drain.
- Decouples host timing from the SPI bit clock; single clock domain.

---
 rtl/spi_byte_queue_if.sv | 34 +++
 rtl/spi_byte_queue.sv | 168 ++++++++++++++++
 tb/tb_spi_byte_queue.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_byte_queue_if.sv
// Host-side and SPI_cont-side handshake signals of spi_byte_queue, bundled together.
// slave is the queue's view; master is the view of whatever drives it (host plus SPI_cont).
interface spi_byte_queue_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  PUSH;
  logic [7:0]            PUSH_DATA;
  logic                  TX_FULL;
  logic [DEPTH_LOG2:0]   TX_LEVEL;
  logic                  POP;
  logic [7:0]            POP_DATA;
  logic                  RX_EMPTY;
  logic [DEPTH_LOG2:0]   RX_LEVEL;
  logic                  W_STB;
  logic [7:0]            W_DATA;
  logic                  W_ACK;
  logic                  R_STB;
  logic [7:0]            R_DATA;
  logic                  R_ACK;
  logic                  BUSY;
  logic                  RX_OVF;

  modport slave (
    input  PUSH, PUSH_DATA, POP, W_ACK, R_STB, R_DATA,
    output TX_FULL, TX_LEVEL, POP_DATA, RX_EMPTY, RX_LEVEL,
           W_STB, W_DATA, R_ACK, BUSY, RX_OVF
  );

  modport master (
    output PUSH, PUSH_DATA, POP, W_ACK, R_STB, R_DATA,
    input  TX_FULL, TX_LEVEL, POP_DATA, RX_EMPTY, RX_LEVEL,
           W_STB, W_DATA, R_ACK, BUSY, RX_OVF
  );
endinterface

// File: rtl/spi_byte_queue.sv
// TX/RX byte FIFOs between a host and SPI_cont, with a three-state write requester.
// Optional macro SPI_QUEUE_RX_OVF_EN: when RX is full, acknowledge and drop bytes, set sticky RX_OVF.
module spi_byte_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic               IN_SCLK,
  input  logic               RST,
  spi_byte_queue_if.slave    bus
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LV = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } wr_state_t;

  logic [7:0] tx_mem [DEPTH];
  logic [7:0] rx_mem [DEPTH];

  wr_state_t             state_q, state_d;
  logic                  w_stb_q, w_stb_d;
  logic [7:0]            w_data_q, w_data_d;
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [DEPTH_LOG2-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   tx_level_q, tx_level_d;
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2:0]   rx_level_q, rx_level_d;
  logic                  r_ack_q, r_ack_d;
  logic [7:0]            pop_data_q, pop_data_d;

  logic tx_full, tx_push, tx_pop;
  logic rx_full, rx_offer, rx_wr, rx_pop;

  assign tx_full = (tx_level_q == DEPTH_LV);
  assign rx_full = (rx_level_q == DEPTH_LV);

  // Write requester: W_STB/W_DATA are registered, head is popped on the acknowledging edge.
  always_comb begin
    state_d  = state_q;
    w_stb_d  = w_stb_q;
    w_data_d = w_data_q;
    tx_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_level_q != '0) begin
          w_stb_d  = 1'b1;
          w_data_d = tx_mem[tx_rd_ptr_q];
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.W_ACK) begin
          tx_pop  = 1'b1;
          w_stb_d = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign tx_push = bus.PUSH && (!tx_full || tx_pop);

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_level_d = tx_level_q + 1'b1;
      2'b01:   tx_level_d = tx_level_q - 1'b1;
      default: tx_level_d = tx_level_q;
    endcase
  end

  // The R_ACK cycle never re-captures, so a held R_STB yields exactly one byte.
  assign rx_offer = bus.R_STB && !r_ack_q;
  assign rx_wr    = rx_offer && !rx_full;
  assign rx_pop   = bus.POP && (rx_level_q != '0);

`ifdef SPI_QUEUE_RX_OVF_EN
  logic rx_ovf_q, rx_ovf_d;
  assign r_ack_d  = rx_offer;
  assign rx_ovf_d = rx_ovf_q | (rx_offer && rx_full);
`else
  assign r_ack_d  = rx_wr;
`endif

  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_level_d  = rx_level_q;
    pop_data_d  = pop_data_q;
    if (rx_wr)  rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
    if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
    case ({rx_wr, rx_pop})
      2'b10:   rx_level_d = rx_level_q + 1'b1;
      2'b01:   rx_level_d = rx_level_q - 1'b1;
      default: rx_level_d = rx_level_q;
    endcase
    // Registered FWFT head: bypass the incoming byte when it becomes the head.
    if (rx_level_d != '0) begin
      if (rx_wr && (rx_wr_ptr_q == rx_rd_ptr_d)) pop_data_d = bus.R_DATA;
      else                                       pop_data_d = rx_mem[rx_rd_ptr_d];
    end
  end

  always_ff @(posedge IN_SCLK) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.PUSH_DATA;
    if (rx_wr)   rx_mem[rx_wr_ptr_q] <= bus.R_DATA;
  end

  always_ff @(posedge IN_SCLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      w_stb_q     <= 1'b0;
      w_data_q    <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_level_q  <= '0;
      r_ack_q     <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_stb_q     <= w_stb_d;
      w_data_q    <= w_data_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_level_q  <= rx_level_d;
      r_ack_q     <= r_ack_d;
      pop_data_q  <= pop_data_d;
    end
  end

`ifdef SPI_QUEUE_RX_OVF_EN
  always_ff @(posedge IN_SCLK) begin
    if (RST) rx_ovf_q <= 1'b0;
    else     rx_ovf_q <= rx_ovf_d;
  end
  assign bus.RX_OVF = rx_ovf_q;
`else
  assign bus.RX_OVF = 1'b0;
`endif

  assign bus.TX_FULL  = tx_full;
  assign bus.TX_LEVEL = tx_level_q;
  assign bus.POP_DATA = pop_data_q;
  assign bus.RX_EMPTY = (rx_level_q == '0);
  assign bus.RX_LEVEL = rx_level_q;
  assign bus.W_STB    = w_stb_q;
  assign bus.W_DATA   = w_data_q;
  assign bus.R_ACK    = r_ack_q;
  assign bus.BUSY     = (tx_level_q != '0) || w_stb_q;

endmodule

// File: tb/tb_spi_byte_queue.sv
// Randomized bench for spi_byte_queue against a queue-based reference model.
// Stimulus phases bias toward TX-full, RX-full and idle traffic; resets are sprinkled in.
module tb_spi_byte_queue;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  spi_byte_queue_if #(.DEPTH_LOG2(3)) bus ();

  spi_byte_queue #(.DEPTH_LOG2(3)) dut (
    .IN_SCLK (clk),
    .RST     (rst_i),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Stimulus copies
  logic       push_i, pop_i, w_ack_i, r_stb_i;
  logic [7:0] push_data_i, r_data_i;

  // Reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         m_stb, m_rack, m_ovf;
  logic [7:0] m_wdata;
  int         m_cool;     // cycles W_STB must still stay low after a completed transfer
  int         last_rise;
  bit         prev_stb;

  task automatic model_step();
    int  txn, rxn;
    bit  ack_take, offer, cap;
    txn = tx_q.size();
    rxn = rx_q.size();
    if (rst_i) begin
      tx_q.delete();
      rx_q.delete();
      m_stb = 0; m_rack = 0; m_ovf = 0; m_wdata = 8'h00; m_cool = 0;
      return;
    end
    ack_take = m_stb && w_ack_i;
    if (m_stb) begin
      if (ack_take) begin
        m_stb  = 0;
        m_cool = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (txn > 0) begin
      m_stb   = 1;
      m_wdata = tx_q[0];
    end
    if (ack_take) void'(tx_q.pop_front());
    if (push_i && (txn < 8 || ack_take)) tx_q.push_back(push_data_i);

    offer = r_stb_i && !m_rack;
    cap   = offer && (rxn < 8);
    if (pop_i && rxn > 0) void'(rx_q.pop_front());
    if (cap) rx_q.push_back(r_data_i);
`ifdef SPI_QUEUE_RX_OVF_EN
    m_rack = offer;
    if (offer && rxn == 8) m_ovf = 1;
`else
    m_rack = cap;
`endif
  endtask

  task automatic check_all();
    check_val("tx_level", 32'(bus.TX_LEVEL), 32'(tx_q.size()));
    check_val("tx_full",  32'(bus.TX_FULL),  32'(tx_q.size() == 8));
    check_val("w_stb",    32'(bus.W_STB),    32'(m_stb));
    check_val("w_data",   32'(bus.W_DATA),   32'(m_wdata));
    check_val("busy",     32'(bus.BUSY),     32'(tx_q.size() > 0 || m_stb));
    check_val("rx_level", 32'(bus.RX_LEVEL), 32'(rx_q.size()));
    check_val("rx_empty", 32'(bus.RX_EMPTY), 32'(rx_q.size() == 0));
    check_val("r_ack",    32'(bus.R_ACK),    32'(m_rack));
    check_val("rx_ovf",   32'(bus.RX_OVF),   32'(m_ovf));
    if (rx_q.size() > 0) check_val("pop_data", 32'(bus.POP_DATA), 32'(rx_q[0]));
    if (bus.W_STB === 1'b1 && !prev_stb) begin
      if (last_rise >= 0) check_val("rise_gap", 32'(cyc - last_rise >= 3), 32'd1);
      last_rise = cyc;
    end
    if (rst_i) last_rise = -1;
    prev_stb = (bus.W_STB === 1'b1);
  endtask

  initial begin
    int push_pct, ack_pct, rstb_pct, pop_pct, phase;
    rst_i = 1'b1;
    push_i = 0; pop_i = 0; w_ack_i = 0; r_stb_i = 0;
    push_data_i = 8'h00; r_data_i = 8'h00;
    m_stb = 0; m_rack = 0; m_ovf = 0; m_wdata = 8'h00; m_cool = 0;
    last_rise = -1; prev_stb = 0;
    bus.PUSH = 0; bus.PUSH_DATA = 0; bus.POP = 0;
    bus.W_ACK = 0; bus.R_STB = 0; bus.R_DATA = 0;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      cyc   = c;
      phase = (c / 400) % 4;
      case (phase)
        0:       begin push_pct = 50; ack_pct = 50; rstb_pct = 40; pop_pct = 50; end
        1:       begin push_pct = 90; ack_pct = 15; rstb_pct = 20; pop_pct = 60; end
        2:       begin push_pct = 20; ack_pct = 60; rstb_pct = 90; pop_pct = 10; end
        default: begin push_pct = 10; ack_pct = 80; rstb_pct = 10; pop_pct = 80; end
      endcase
      rst_i       = (c < 3) || ($urandom_range(0, 349) == 0);
      push_i      = ($urandom_range(0, 99) < push_pct);
      push_data_i = 8'($urandom);
      w_ack_i     = ($urandom_range(0, 99) < ack_pct);
      pop_i       = ($urandom_range(0, 99) < pop_pct);
      // SPI_cont-like source: hold a byte until acknowledged, then maybe offer another
      if (bus.R_ACK === 1'b1) r_stb_i = 1'b0;
      if (!r_stb_i && ($urandom_range(0, 99) < rstb_pct)) begin
        r_stb_i  = 1'b1;
        r_data_i = 8'($urandom);
      end
      bus.PUSH = push_i; bus.PUSH_DATA = push_data_i;
      bus.POP = pop_i; bus.W_ACK = w_ack_i;
      bus.R_STB = r_stb_i; bus.R_DATA = r_data_i;

      @(posedge clk);
      model_step();
      #1;
      check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
